// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, NOP encoding, PC step and fetch-state encoding.
package cpu_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic {
        FETCH_FILL = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_stage_pipe_reg.sv
// Width-parameterised pipeline register: sync reset, clear (flush) beats hold, hold beats load.
module pipe_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register update with flush priority over hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IM addressing, IF/ID capture, stall/flush, fetch counter.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IM_WORDS = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [31:0]        branch_target_i,
    input  logic [INSTR_W-1:0] im_data_i,
    output logic [31:0]        im_addr_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic               ifid_valid_o,
    output logic               oor_o,
    output logic [CNT_W-1:0]   fetch_cnt_o
);

    localparam logic [31:0] IM_LIMIT = 32'(IM_WORDS * 4);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             oor_q, oor_d;
    logic             advance_c;
    logic [31:0]      pc_plus4_c;

    assign advance_c  = !branch_taken_i && !stall_i;
    assign pc_plus4_c = pc_q + PC_INC;

    // Next-state for FSM, PC, counter and out-of-range flag; branch > stall > advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        oor_d   = oor_q;
        case (state_q)
            FETCH_FILL: state_d = FETCH_RUN;
            FETCH_RUN:  state_d = FETCH_RUN;
            default:    state_d = FETCH_RUN;
        endcase
        if (branch_taken_i) begin
            pc_d = branch_target_i & ~32'h0000_0003;
        end else if (!stall_i) begin
            pc_d = pc_plus4_c;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (pc_q >= IM_LIMIT) begin
                oor_d = 1'b1;
            end
        end
    end

    // State, PC, counter and sticky flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH_FILL;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            oor_q   <= oor_d;
        end
    end

    pipe_reg #(.W(INSTR_W)) u_instr (
        .clk   (clk_i),
        .rst   (rst_i),
        .hold  (stall_i),
        .clear (branch_taken_i),
        .d     (advance_c ? im_data_i : NOP_INSTR),
        .q     (ifid_instr_o)
    );

    pipe_reg #(.W(32)) u_pc4 (
        .clk   (clk_i),
        .rst   (rst_i),
        .hold  (stall_i),
        .clear (branch_taken_i),
        .d     (pc_plus4_c),
        .q     (ifid_pc4_o)
    );

    pipe_reg #(.W(1)) u_valid (
        .clk   (clk_i),
        .rst   (rst_i),
        .hold  (stall_i),
        .clear (branch_taken_i),
        .d     (1'b1),
        .q     (ifid_valid_o)
    );

    assign im_addr_o   = pc_q;
    assign pc_o        = pc_q;
    assign oor_o       = oor_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed table, corner sequences, randomized model comparison.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic [31:0] im_data;
    logic [31:0] im_addr, pc, ifid_pc4, ifid_instr;
    logic        ifid_valid, oor;
    logic [3:0]  fetch_cnt;

    logic [31:0] im [0:31];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instruction memory: combinational read, zero outside the populated range.
    always_comb begin
        if (im_addr < 32'd128) im_data = im[im_addr[6:2]];
        else                   im_data = 32'h0;
    end

    if_stage #(.RESET_PC(32'h0), .IM_WORDS(32), .CNT_W(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .branch_taken_i (br),
        .branch_target_i(tgt),
        .im_data_i      (im_data),
        .im_addr_o      (im_addr),
        .pc_o           (pc),
        .ifid_pc4_o     (ifid_pc4),
        .ifid_instr_o   (ifid_instr),
        .ifid_valid_o   (ifid_valid),
        .oor_o          (oor),
        .fetch_cnt_o    (fetch_cnt)
    );

    typedef struct {
        logic        rst, stall, br;
        logic [31:0] tgt;
        logic [31:0] pc, instr, pc4;
        logic        valid, oor;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid, input logic e_oor,
                           input logic [3:0] e_cnt);
        chk({tag, ".pc"},      pc, e_pc);
        chk({tag, ".im_addr"}, im_addr, e_pc);
        chk({tag, ".instr"},   ifid_instr, e_instr);
        chk({tag, ".pc4"},     ifid_pc4, e_pc4);
        chk({tag, ".valid"},   32'(ifid_valid), 32'(e_valid));
        chk({tag, ".oor"},     32'(oor), 32'(e_oor));
        chk({tag, ".cnt"},     32'(fetch_cnt), 32'(e_cnt));
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t);
        rst = r; stall = s; br = b; tgt = t;
        @(posedge clk);
        #1;
    endtask

    // Reference model state, updated from the fetch rules directly.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_oor;
    int          m_cnt;

    task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t);
        if (r) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_oor = 0; m_cnt = 0;
        end else if (b) begin
            m_pc = {t[31:2], 2'b00}; m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (!s) begin
            m_instr = (m_pc < 128) ? im[m_pc / 4] : 32'h0;
            if (m_pc >= 128) m_oor = 1;
            m_pc4 = m_pc + 4;
            m_valid = 1;
            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            m_pc = m_pc + 4;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) im[i] = 32'hC0DE_0000 + 32'(i);

        //          rst   stall br    tgt          pc           instr         pc4          v     oor   cnt
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h00, 32'h0,           32'h00, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h04, 32'hC0DE_0000,   32'h04, 1'b1, 1'b0, 4'd1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h08, 32'hC0DE_0001,   32'h08, 1'b1, 1'b0, 4'd2};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h08, 32'hC0DE_0001,   32'h08, 1'b1, 1'b0, 4'd2};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h08, 32'hC0DE_0001,   32'h08, 1'b1, 1'b0, 4'd2};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0C, 32'hC0DE_0002,   32'h0C, 1'b1, 1'b0, 4'd3};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h10, 32'hC0DE_0003,   32'h10, 1'b1, 1'b0, 4'd4};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h14, 32'h14, 32'h0,           32'h00, 1'b0, 1'b0, 4'd4};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h18, 32'hC0DE_0005,   32'h18, 1'b1, 1'b0, 4'd5};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h1B, 32'h18, 32'h0,           32'h00, 1'b0, 1'b0, 4'd5};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h1C, 32'hC0DE_0006,   32'h1C, 1'b1, 1'b0, 4'd6};

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].tgt);
            chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].instr, tbl[i].pc4,
                    tbl[i].valid, tbl[i].oor, tbl[i].cnt);
        end

        // Out-of-range fetch, sticky flag, PC wrap, then reset overriding stall+branch.
        cyc(0, 0, 1, 32'h7C);         chk_all("oor_br",   32'h7C, 32'h0, 32'h0, 0, 0, 4'd6);
        cyc(0, 0, 0, 0);              chk_all("last_in",  32'h80, 32'hC0DE_001F, 32'h80, 1, 0, 4'd7);
        cyc(0, 0, 0, 0);              chk_all("oor_set",  32'h84, 32'h0, 32'h84, 1, 1, 4'd8);
        cyc(0, 0, 1, 32'h0);          chk_all("oor_hold", 32'h0, 32'h0, 32'h0, 0, 1, 4'd8);
        cyc(0, 0, 0, 0);              chk_all("oor_run",  32'h4, 32'hC0DE_0000, 32'h4, 1, 1, 4'd9);
        cyc(0, 0, 1, 32'hFFFF_FFFF);  chk_all("top_br",   32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1, 4'd9);
        cyc(0, 0, 0, 0);              chk_all("wrap",     32'h0, 32'h0, 32'h0, 1, 1, 4'd10);
        cyc(1, 1, 1, 32'h40);         chk_all("rst_ovr",  32'h0, 32'h0, 32'h0, 0, 0, 4'd0);
        for (int i = 1; i <= 20; i++) begin
            cyc(0, 0, 0, 0);
            if (i == 15) chk_all("sat15", 32'h3C, 32'hC0DE_000E, 32'h3C, 1, 0, 4'd15);
        end
        chk_all("sat20", 32'h50, 32'hC0DE_0013, 32'h50, 1, 0, 4'd15);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 32; i++) im[i] = $urandom;
        model_step(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_all("rnd_rst", m_pc, m_instr, m_pc4, m_valid, m_oor, 4'(m_cnt));
        for (int i = 0; i < 600; i++) begin
            logic        r, s, b;
            logic [31:0] t;
            r = ($urandom_range(0, 63) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 160));
            model_step(r, s, b, t);
            cyc(r, s, b, t);
            chk_all($sformatf("rnd%0d", i), m_pc, m_instr, m_pc4, m_valid, m_oor, 4'(m_cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
